// File: rtl/cues_arb_pkg.sv
// Shared types and helpers for the C-element ring token-injection arbiter.
package cues_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        SEND_LO,
        DONE,
        ERROR
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int MAX_REQ         = 8;

    // Lowest-distance set request strictly after ptr, wrapping modulo n; zero if none.
    function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] pick;
        logic [2:0]         idx;
        pick = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                idx = 3'((int'(ptr) + i) % n);
                if (req[idx]) begin
                    pick      = '0;
                    pick[idx] = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cues_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, resets to 0.
module cues_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cues_token_arbiter.sv
// Round-robin arbiter granting the ring's single token-injection port through
// a four-phase SENDOUT/ACKIN handshake, with stall timeout and token counting.
module cues_token_arbiter
    import cues_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_err_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             sendout_o,
    input  logic             ackin_i,
    output logic             lopen_o,
    output logic [CNT_W-1:0] token_cnt_o,
    output logic             err_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [TW-1:0]      phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sendout_q, sendout_d;
    logic               err_q, err_d;
    logic               lopen_q;
    logic               ack_s;
    logic [MAX_REQ-1:0] pick;

    cues_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (ackin_i),
        .q_o   (ack_s)
    );

    assign pick = rr_next(MAX_REQ'(req_i), 3'(ptr_q), NREQ);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            phase_q   <= '0;
            cnt_q     <= '0;
            sendout_q <= 1'b0;
            err_q     <= 1'b0;
            lopen_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            sendout_q <= sendout_d;
            err_q     <= err_d;
            lopen_q   <= en_i;
        end
    end

    // An in-flight handshake always runs to completion; EN only gates new grants.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        sendout_d = sendout_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && !ack_s && (|pick)) begin
                    gnt_d     = pick[NREQ-1:0];
                    sendout_d = 1'b1;
                    phase_d   = '0;
                    state_d   = SEND_HI;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick[i]) begin
                            ptr_d = PW'(i);
                        end
                    end
                end
            end
            SEND_HI: begin
                if (ack_s) begin
                    sendout_d = 1'b0;
                    phase_d   = '0;
                    state_d   = SEND_LO;
                end else if (phase_q == TW'(TIMEOUT)) begin
                    sendout_d = 1'b0;
                    gnt_d     = '0;
                    err_d     = 1'b1;
                    state_d   = ERROR;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            SEND_LO: begin
                if (!ack_s) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = DONE;
                end else if (phase_q == TW'(TIMEOUT)) begin
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            ERROR: begin
                sendout_d = 1'b0;
                gnt_d     = '0;
                err_d     = 1'b1;
                if (clr_err_i && !ack_s) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sendout_o   = sendout_q;
    assign lopen_o     = lopen_q;
    assign token_cnt_o = cnt_q;
    assign err_o       = err_q;

endmodule
